// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full adder processes one operand bit per
// clock, LSB first, with the result, carry-out and signed overflow registered at completion.
module serial_adder #(
   parameter int WIDTH  = 8,
   parameter bit SUB_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] res_sh_r;
   logic [WIDTH-1:0] res_next_s;
   logic             carry_r;
   logic             bit_sum_s;
   logic             bit_co_s;
   logic             last_s;
   logic             load_s;
   logic             step_s;
   logic             finish_s;
   logic             sub_eff_s;

   // Single-bit full adder: returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

   // Bit-slice datapath: current bit sum/carry and the shifted result.
   always_comb begin
      sub_eff_s             = sub & SUB_EN;
      {bit_co_s, bit_sum_s} = full_add(a_sh_r[0], b_sh_r[0], carry_r);
      res_next_s            = res_sh_r >> 1'b1;
      res_next_s[WIDTH-1]   = bit_sum_s;
      last_s                = (cnt_r == CW'(WIDTH - 1));
   end

   // Next-state logic; the completing edge may also accept a new start so
   // back-to-back operations run without a gap.
   always_comb begin
      state_s  = state_r;
      load_s   = 1'b0;
      step_s   = 1'b0;
      finish_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               load_s  = 1'b1;
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            step_s = 1'b1;
            if (last_s) begin
               finish_s = 1'b1;
               if (start) begin
                  load_s  = 1'b1;
                  state_s = RUN;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = RUN;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Operand shift registers, carry and bit counter; subtract folds into ~b and inverted carry-in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         res_sh_r <= '0;
         carry_r  <= 1'b0;
         cnt_r    <= '0;
      end else begin
         if (load_s) begin
            a_sh_r  <= a;
            b_sh_r  <= sub_eff_s ? ~b : b;
            carry_r <= c_in ^ sub_eff_s;
            cnt_r   <= '0;
         end else if (step_s) begin
            a_sh_r  <= a_sh_r >> 1'b1;
            b_sh_r  <= b_sh_r >> 1'b1;
            carry_r <= bit_co_s;
            cnt_r   <= cnt_r + CW'(1'b1);
         end else begin
            a_sh_r  <= a_sh_r;
            b_sh_r  <= b_sh_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
         end
         if (step_s) begin
            res_sh_r <= res_next_s;
         end else begin
            res_sh_r <= res_sh_r;
         end
      end
   end

   // Result and status outputs; overflow is carry-into-MSB xor carry-out-of-MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum   <= '0;
         c_out <= 1'b0;
         ovf   <= 1'b0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         if (finish_s) begin
            sum   <= res_next_s;
            c_out <= bit_co_s;
            ovf   <= carry_r ^ bit_co_s;
         end else begin
            sum   <= sum;
            c_out <= c_out;
            ovf   <= ovf;
         end
         done <= finish_s;
         busy <= (state_s == RUN);
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances share control
// inputs; expected results come from an arithmetic reference model.
module tb_serial_adder;

   typedef struct {
      longint s;
      bit     co;
      bit     ov;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n, start, c_in, sub;
   logic [7:0] a8, b8, sum8;
   logic       a1, b1, sum1;
   logic       busy8, done8, cout8, ovf8;
   logic       busy1, done1, cout1, ovf1;

   res_t   q8[$];
   res_t   q1[$];
   int     total = 0;
   int     bad = 0;
   int     rem8 = 0;
   int     rem1 = 0;
   bit     fin8 = 1'b0;
   bit     fin1 = 1'b0;
   longint hold8 = 0;
   longint hold1 = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .SUB_EN(1'b1)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a8), .b(b8), .c_in(c_in), .sub(sub),
      .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .ovf(ovf8)
   );

   serial_adder #(.WIDTH(1), .SUB_EN(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1), .c_in(c_in), .sub(sub),
      .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1), .ovf(ovf1)
   );

   // Reference: plain integer arithmetic on unsigned and signed views of the operands.
   function automatic res_t ref_op(int w, longint av, longint bv, bit ci, bit sb);
      res_t   r;
      longint m    = longint'(1) << w;
      longint half = m >> 1;
      longint sa   = (av >= half) ? av - m : av;
      longint sbv  = (bv >= half) ? bv - m : bv;
      longint u, sr;
      if (!sb) begin
         u    = av + bv + longint'(ci);
         r.s  = u % m;
         r.co = (u >= m);
         sr   = sa + sbv + longint'(ci);
      end else begin
         u    = av - bv - longint'(ci);
         r.s  = (u + m) % m;
         r.co = (u >= 0);
         sr   = sa - sbv - longint'(ci);
      end
      r.ov = (sr >= half) || (sr < -half);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then advance the transaction-level model past the edge.
   task automatic step(input bit st, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input logic sb, input logic a1v, input logic b1v);
      start = st; a8 = av; b8 = bv; c_in = ci; sub = sb; a1 = a1v; b1 = b1v;
      @(posedge clk);
      fin8 = (rem8 == 1);
      if (rem8 > 0) rem8--;
      if (st && rem8 == 0) begin
         q8.push_back(ref_op(8, longint'(av), longint'(bv), ci, sb));
         rem8 = 8;
      end
      fin1 = (rem1 == 1);
      if (rem1 > 0) rem1--;
      if (st && rem1 == 0) begin
         q1.push_back(ref_op(1, longint'(a1v), longint'(b1v), ci, sb));
         rem1 = 1;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom));
   endtask

   task automatic check_zero();
      chk("rst_busy8", 64'(busy8), 64'(0)); chk("rst_done8", 64'(done8), 64'(0));
      chk("rst_sum8", 64'(sum8), 64'(0));   chk("rst_cout8", 64'(cout8), 64'(0));
      chk("rst_ovf8", 64'(ovf8), 64'(0));   chk("rst_busy1", 64'(busy1), 64'(0));
      chk("rst_done1", 64'(done1), 64'(0)); chk("rst_sum1", 64'(sum1), 64'(0));
      chk("rst_cout1", 64'(cout1), 64'(0)); chk("rst_ovf1", 64'(ovf1), 64'(0));
   endtask

   // Asynchronous reset pulse placed between clock edges; pending operations are dropped.
   task automatic pulse_reset();
      #1 rst_n = 1'b0;
      #1 check_zero();
      q8.delete(); q1.delete();
      rem8 = 0; rem1 = 0; fin8 = 1'b0; fin1 = 1'b0; hold8 = 0; hold1 = 0;
      #1 rst_n = 1'b1;
   endtask

   // Monitor: pops the scoreboard on each done and checks busy/done timing and result hold.
   always @(negedge clk) begin
      res_t e;
      chk("busy8", 64'(busy8), 64'(rem8 > 0));
      chk("done8", 64'(done8), 64'(fin8));
      if (done8) begin
         if (q8.size() == 0) begin
            chk("done8_expected", 64'(0), 64'(1));
         end else begin
            e = q8.pop_front();
            chk("sum8", 64'(sum8), 64'(e.s));
            chk("cout8", 64'(cout8), 64'(e.co));
            chk("ovf8", 64'(ovf8), 64'(e.ov));
            hold8 = e.s;
         end
      end else begin
         chk("hold8", 64'(sum8), 64'(hold8));
      end
      chk("busy1", 64'(busy1), 64'(rem1 > 0));
      chk("done1", 64'(done1), 64'(fin1));
      if (done1) begin
         if (q1.size() == 0) begin
            chk("done1_expected", 64'(0), 64'(1));
         end else begin
            e = q1.pop_front();
            chk("sum1", 64'(sum1), 64'(e.s));
            chk("cout1", 64'(cout1), 64'(e.co));
            chk("ovf1", 64'(ovf1), 64'(e.ov));
            hold1 = e.s;
         end
      end else begin
         chk("hold1", 64'(sum1), 64'(hold1));
      end
   end

   initial begin
      rst_n = 1'b1; start = 1'b0; a8 = 8'h00; b8 = 8'h00; c_in = 1'b0; sub = 1'b0;
      a1 = 1'b0; b1 = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_zero();
      #1 rst_n = 1'b1;

      // Directed vectors; the first start lands on the first edge after reset release.
      step(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); idle(9);
      step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0); idle(9);
      step(1'b1, 8'h7F, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1); idle(9);
      step(1'b1, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1); idle(9);

      // Start while busy is ignored; start on the completing edge chains directly.
      step(1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0); idle(3);
      step(1'b1, 8'h99, 8'h99, 1'b1, 1'b1, 1'b1, 1'b0); idle(3);
      step(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0); idle(9);

      // Start raised in the cycle where done is visible.
      step(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0); idle(8);
      step(1'b1, 8'h0F, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0); idle(9);

      // Reset mid-operation, then the same operands again.
      step(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0); idle(4);
      pulse_reset();
      step(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0); idle(9);
      step(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1); idle(9);

      // Start held high continuously.
      repeat (32) step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom));
      idle(9);

      // Random traffic with occasional resets.
      repeat (600) begin
         step(($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 99) == 0) pulse_reset();
      end
      idle(10);

      chk("q8_drained", 64'(q8.size()), 64'(0));
      chk("q1_drained", 64'(q1.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
